// File: rtl/ahb_decoder_mux_pkg.sv
// AHB-lite decoder/mux shared definitions.
// HTRANS/HRESP codes and default-slave state encodings.
package ahb_decoder_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  function automatic logic is_active(
    input logic [1:0] htrans
  );
    return (htrans == HTRANS_NONSEQ) ||
           (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR for unmapped active transfers.
// Ports: HCLK, HRESETn, sel, HTRANS, HADDR -> HREADYOUT, HRESP, err_cnt, err_addr.
module ahb_default_slave
  import ahb_decoder_mux_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                sel,
  input  logic [1:0]          HTRANS,
  input  logic [ADDR_W-1:0]   HADDR,
  output logic                HREADYOUT,
  output logic [1:0]          HRESP,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]   err_addr
);

  ds_state_t             r_state;
  ds_state_t             w_next;
  logic                  w_qual;
  logic                  w_enter;
  logic [ERRCNT_W-1:0]   r_err_cnt;
  logic [ADDR_W-1:0]     r_err_addr;

  // sel already carries miss & HREADY
  assign w_qual = sel && is_active(HTRANS);

  always_comb begin
    w_next    = r_state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (r_state)
      DS_IDLE: begin
        if (w_qual) w_next = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        w_next    = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP  = HRESP_ERROR;
        w_next = w_qual ? DS_ERR1 : DS_IDLE;
      end
      default: w_next = DS_IDLE;
    endcase
  end

  // ERR1 never loops to itself, so this is exactly an entry
  assign w_enter = (w_next == DS_ERR1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= DS_IDLE;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_enter) begin
        r_err_addr <= HADDR;
        if (r_err_cnt != '1)
          r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err_cnt  = r_err_cnt;
  assign err_addr = r_err_addr;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-lite address decoder and slave response multiplexer.
// Ports: master addr/trans in, muxed resp out; per-slave HSEL out, slave resp in; debug err_cnt/err_addr.
module ahb_decoder_mux
  import ahb_decoder_mux_pkg::*;
#(
  parameter int NUM_SLV  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK =
    {32'hF000_0000, 32'hF000_0000},
  parameter int ERRCNT_W = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [ADDR_W-1:0]         m_HADDR,
  input  logic [1:0]                m_HTRANS,
  output logic [DATA_W-1:0]         m_HRDATA,
  output logic [1:0]                m_HRESP,
  output logic                      m_HREADY,
  output logic [NUM_SLV-1:0]        s_HSEL,
  input  logic [NUM_SLV*DATA_W-1:0] s_HRDATA,
  input  logic [NUM_SLV*2-1:0]      s_HRESP,
  input  logic [NUM_SLV-1:0]        s_HREADYOUT,
  output logic [ERRCNT_W-1:0]       err_cnt,
  output logic [ADDR_W-1:0]         err_addr
);

  localparam logic [NUM_SLV:0] DSEL_RST =
    {1'b1, {NUM_SLV{1'b0}}};

  logic [NUM_SLV-1:0] w_raw;
  logic [NUM_SLV-1:0] w_hit;
  logic               w_found;
  logic               w_miss;
  logic [NUM_SLV:0]   r_dsel;
  logic               w_ds_ready;
  logic [1:0]         w_ds_resp;

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_dec
    assign w_raw[gi] =
      (m_HADDR & SLV_MASK[gi*ADDR_W +: ADDR_W]) ==
      SLV_BASE[gi*ADDR_W +: ADDR_W];
  end

  // lowest index wins on overlapping windows
  always_comb begin
    w_hit   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_raw[i] && !w_found) begin
        w_hit[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_miss = ~|w_raw;
  assign s_HSEL = w_hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_dsel <= DSEL_RST;
    else if (m_HREADY)
      r_dsel <= {w_miss, w_hit};
  end

  ahb_default_slave #(
    .ADDR_W   (ADDR_W),
    .ERRCNT_W (ERRCNT_W)
  ) u_dflt (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (w_miss & m_HREADY),
    .HTRANS    (m_HTRANS),
    .HADDR     (m_HADDR),
    .HREADYOUT (w_ds_ready),
    .HRESP     (w_ds_resp),
    .err_cnt   (err_cnt),
    .err_addr  (err_addr)
  );

  // dsel is one-hot; default slave is the fallback
  always_comb begin
    m_HRDATA = '0;
    m_HRESP  = w_ds_resp;
    m_HREADY = w_ds_ready;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_dsel[i]) begin
        m_HRDATA = s_HRDATA[i*DATA_W +: DATA_W];
        m_HRESP  = s_HRESP[i*2 +: 2];
        m_HREADY = s_HREADYOUT[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux (2 slaves, 2-bit error counter).
// Drives 1 ns after posedge, checks at negedge.
module tb_ahb_decoder_mux;
  import ahb_decoder_mux_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] m_HADDR;
  logic [1:0]  m_HTRANS;
  logic [31:0] m_HRDATA;
  logic [1:0]  m_HRESP;
  logic        m_HREADY;
  logic [1:0]  s_HSEL;
  logic [63:0] s_HRDATA;
  logic [3:0]  s_HRESP;
  logic [1:0]  s_HREADYOUT;
  logic [1:0]  err_cnt;
  logic [31:0] err_addr;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int failures = 0;

  assign s_HRDATA = {rd1, rd0};

  always #5 HCLK = ~HCLK;

  ahb_decoder_mux #(.ERRCNT_W(2)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .m_HADDR     (m_HADDR),
    .m_HTRANS    (m_HTRANS),
    .m_HRDATA    (m_HRDATA),
    .m_HRESP     (m_HRESP),
    .m_HREADY    (m_HREADY),
    .s_HSEL      (s_HSEL),
    .s_HRDATA    (s_HRDATA),
    .s_HRESP     (s_HRESP),
    .s_HREADYOUT (s_HREADYOUT),
    .err_cnt     (err_cnt),
    .err_addr    (err_addr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [31:0] a,
                     input logic [1:0] t);
    m_HADDR  = a;
    m_HTRANS = t;
  endtask

  initial begin
    HRESETn = 1'b0;
    drv(32'h0, HTRANS_IDLE);
    rd0 = 32'hAAAA_0000;
    rd1 = 32'hBBBB_0000;
    s_HRESP = 4'b0000;
    s_HREADYOUT = 2'b11;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_ready", 32'(m_HREADY), 32'd1);
    chk("rst_resp", 32'(m_HRESP), 32'd0);
    chk("rst_rdata", m_HRDATA, 32'h0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_eaddr", err_addr, 32'h0);
    chk("rst_sel", 32'(s_HSEL), 32'h1);

    // read slave 1 with one wait state
    @(posedge HCLK); #1;
    drv(32'h1000_0004, HTRANS_NONSEQ);
    @(negedge HCLK);
    chk("s1_sel", 32'(s_HSEL), 32'h2);
    chk("s1_aready", 32'(m_HREADY), 32'd1);
    @(posedge HCLK); #1;
    drv(32'h0, HTRANS_IDLE);
    s_HREADYOUT = 2'b01;
    @(negedge HCLK);
    chk("s1_wait", 32'(m_HREADY), 32'd0);
    @(posedge HCLK); #1;
    s_HREADYOUT = 2'b11;
    rd1 = 32'hCAFE_F00D;
    @(negedge HCLK);
    chk("s1_ready", 32'(m_HREADY), 32'd1);
    chk("s1_rdata", m_HRDATA, 32'hCAFE_F00D);
    chk("s1_resp", 32'(m_HRESP), 32'd0);

    // back-to-back slave 0 then slave 1
    @(posedge HCLK); #1;
    drv(32'h0000_0010, HTRANS_NONSEQ);
    @(negedge HCLK);
    chk("b2b_sel0", 32'(s_HSEL), 32'h1);
    @(posedge HCLK); #1;
    drv(32'h1000_0000, HTRANS_NONSEQ);
    rd0 = 32'h0000_1234;
    rd1 = 32'h5555_5555;
    @(negedge HCLK);
    chk("b2b_sel1", 32'(s_HSEL), 32'h2);
    chk("b2b_rd0", m_HRDATA, 32'h0000_1234);
    @(posedge HCLK); #1;
    drv(32'h0, HTRANS_IDLE);
    rd0 = 32'h6666_6666;
    rd1 = 32'h0000_5678;
    @(negedge HCLK);
    chk("b2b_rd1", m_HRDATA, 32'h0000_5678);

    // unmapped NONSEQ -> two-cycle error
    @(posedge HCLK); #1;
    drv(32'h2000_0000, HTRANS_NONSEQ);
    @(negedge HCLK);
    chk("err_sel", 32'(s_HSEL), 32'h0);
    chk("err_aready", 32'(m_HREADY), 32'd1);
    @(posedge HCLK); #1;
    drv(32'h0, HTRANS_IDLE);
    @(negedge HCLK);
    chk("err1_ready", 32'(m_HREADY), 32'd0);
    chk("err1_resp", 32'(m_HRESP), 32'd1);
    chk("err1_cnt", 32'(err_cnt), 32'd1);
    chk("err1_eaddr", err_addr, 32'h2000_0000);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("err2_ready", 32'(m_HREADY), 32'd1);
    chk("err2_resp", 32'(m_HRESP), 32'd1);
    chk("err2_rdata", m_HRDATA, 32'h0);

    // IDLE to unmapped -> zero-wait OKAY
    @(posedge HCLK); #1;
    drv(32'h2000_0000, HTRANS_IDLE);
    @(negedge HCLK);
    chk("idle_aready", 32'(m_HREADY), 32'd1);
    @(posedge HCLK); #1;
    drv(32'h0, HTRANS_IDLE);
    @(negedge HCLK);
    chk("idle_ready", 32'(m_HREADY), 32'd1);
    chk("idle_resp", 32'(m_HRESP), 32'd0);
    chk("idle_rdata", m_HRDATA, 32'h0);
    chk("idle_cnt", 32'(err_cnt), 32'd1);

    // pipelined errors, counter saturation
    @(posedge HCLK); #1;
    drv(32'h3000_0000, HTRANS_NONSEQ);
    @(negedge HCLK);
    chk("sat_aready", 32'(m_HREADY), 32'd1);
    @(posedge HCLK); #1;
    drv(32'h2000_0004, HTRANS_NONSEQ);
    @(negedge HCLK);
    chk("sat_cnt2", 32'(err_cnt), 32'd2);
    chk("sat_e1ready", 32'(m_HREADY), 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("sat_e2ready", 32'(m_HREADY), 32'd1);
    chk("sat_e2resp", 32'(m_HRESP), 32'd1);
    @(posedge HCLK); #1;
    drv(32'h4000_0000, HTRANS_NONSEQ);
    @(negedge HCLK);
    chk("sat_cnt3", 32'(err_cnt), 32'd3);
    chk("sat_eaddr3", err_addr, 32'h2000_0004);
    chk("sat_b2bready", 32'(m_HREADY), 32'd0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("sat_e2bready", 32'(m_HREADY), 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("sat_hold", 32'(err_cnt), 32'd3);
    chk("sat_eaddr4", err_addr, 32'h4000_0000);
    chk("sat_e1b", 32'(m_HREADY), 32'd0);

    // async reset during DS_ERR1
    HRESETn = 1'b0;
    #1;
    chk("arst_ready", 32'(m_HREADY), 32'd1);
    chk("arst_resp", 32'(m_HRESP), 32'd0);
    chk("arst_cnt", 32'(err_cnt), 32'd0);
    chk("arst_eaddr", err_addr, 32'h0);
    chk("arst_rdata", m_HRDATA, 32'h0);
    drv(32'h0, HTRANS_IDLE);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("post_ready", 32'(m_HREADY), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_decoder_mux.md
Name: ahb_decoder_mux

Overview:
Parametrised AHB-lite address decoder and slave-response multiplexer. It connects one master to NUM_SLV slaves. It generates HSEL from address windows and registers the data-phase select so that responses are muxed per the AHB pipeline. An internal default slave returns a two-cycle ERROR for unmapped accesses. A saturating error counter and the last faulting address are exposed for debug.

Parameters:
NUM_SLV, 2, number of slaves (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {0x1000_0000, 0x0000_0000}, NUM_SLV*ADDR_W packed base addresses, slave 0 in LSBs
SLV_MASK, {0xF000_0000, 0xF000_0000}, NUM_SLV*ADDR_W packed compare masks
ERRCNT_W, 16, width of error counter

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
m_HADDR  in  ADDR_W  master address
m_HTRANS  in  2  master transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
m_HRDATA  out  DATA_W  muxed read data to master
m_HRESP  out  2  muxed response (OKAY 00, ERROR 01)
m_HREADY  out  1  muxed ready; also fed to all slaves as HREADYIN
s_HSEL  out  NUM_SLV  per-slave select
s_HRDATA  in  NUM_SLV*DATA_W  slave read data, packed
s_HRESP  in  NUM_SLV*2  slave responses, packed
s_HREADYOUT  in  NUM_SLV  slave ready outputs
err_cnt  out  ERRCNT_W  count of decode errors, saturating
err_addr  out  ADDR_W  address of the most recent decode error

Behaviour:
- Decode (combinational): hit[i] = ((m_HADDR & MASK_i) == BASE_i). On overlapping windows, the lowest index wins, so s_HSEL is one-hot or zero. s_HSEL depends only on the address and is independent of HTRANS. miss = no hit.
- Data-phase select register dsel (NUM_SLV+1 bits, bit NUM_SLV = default slave). It loads {miss, one-hot hit} on every rising HCLK with m_HREADY=1 and holds while m_HREADY=0. Reset value: default bit only.
- Response mux: when dsel[i] is set, m_HRDATA/m_HRESP/m_HREADY = slave i's signals. When the default bit is set, the outputs come from the default slave and m_HRDATA = 0.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2. Reset state is DS_IDLE.
  - DS_IDLE: outputs HREADY=1, HRESP=OKAY. Moves to DS_ERR1 when m_HREADY=1, miss=1 and m_HTRANS is NONSEQ or SEQ. Otherwise stays.
  - DS_ERR1: outputs HREADY=0, HRESP=ERROR. Always moves to DS_ERR2.
  - DS_ERR2: outputs HREADY=1, HRESP=ERROR. Moves to DS_ERR1 if the pipelined next address also qualifies as above; otherwise moves to DS_IDLE.
  - IDLE/BUSY transfers to unmapped space get a zero-wait OKAY. No error is raised and the counter does not count them.
- err_cnt: increments by 1 on each DS_ERR1 entry and saturates at all-ones. It is never cleared except by reset.
- err_addr: loads m_HADDR on the same condition that causes DS_ERR1 entry.
- Latency: the response appears in the data-phase cycle following the address phase. The mux adds no extra cycle.
- Wait states: while the selected slave drives HREADYOUT=0, dsel holds and s_HSEL continues to reflect the held master address.
- Reset values of outputs: m_HREADY=1, m_HRESP=OKAY, m_HRDATA=0, err_cnt=0, err_addr=0. s_HSEL follows m_HADDR.
- Asynchronous reset mid-transfer aborts the transfer immediately: FSM returns to DS_IDLE, dsel returns to default, and counters clear. There is no recovery of the in-flight transfer.

Decomposition:
- Shared package/header: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes (OKAY/ERROR), default-slave state encodings. These extend the existing AHB header constants.
- One sub-module: ahb_default_slave, containing the FSM, err_cnt and err_addr. It takes inputs HCLK, HRESETn, sel (miss & HREADY), HTRANS and HADDR, and outputs HREADYOUT and HRESP.
- Decode and mux stay in the parent as generate loops over NUM_SLV.

Test Plan:
- Reset release, master issues IDLE -> m_HREADY=1, m_HRESP=00, m_HRDATA=0, err_cnt=0.
- NONSEQ read at 0x1000_0004; slave 1 returns 0xCAFE_F00D with one wait state -> s_HSEL=2'b10 in the address phase; m_HREADY low for 1 cycle, then m_HRDATA=0xCAFE_F00D, OKAY.
- Back-to-back NONSEQ: slave 0 at 0x0000_0010, then slave 1 at 0x1000_0000 -> each data phase is muxed from the slave selected in the prior address phase, with no cross-contamination of HRDATA.
- NONSEQ to unmapped 0x2000_0000 -> m_HREADY=0/HRESP=01 for one cycle, then HREADY=1/HRESP=01; err_cnt=1, err_addr=0x2000_0000.
- IDLE to 0x2000_0000 -> zero-wait OKAY; err_cnt unchanged.
- ERRCNT_W=2, four unmapped NONSEQ transfers -> err_cnt saturates at 3. Assert HRESETn low during DS_ERR1 -> FSM returns to DS_IDLE and err_cnt=0 immediately.
